mem_read_buffer: RTL and testbench

MEM_READ_BUFFER -- requirements
Module: mem_read_buffer

---
 rtl/mem_read_buffer.sv | 184 ++++++++++++++++++
 tb/tb_mem_read_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_buffer.sv
// -----------------------------------------------------------------------------
// mem_read_buffer
//
// Small FIFO that sits between a memory read-data source and a load pipeline.
// Every accepted word is written into a DEPTH-entry circular buffer and
// presented to the sink in strict arrival order.
//
// Optional load extraction (compile-time macro MRB_LOAD_EXTRACT_EN):
//   When defined, each word is reduced to the addressed byte/halfword and
//   sign- or zero-extended to 32 bits before it is stored. A halfword access
//   on an odd byte address sets the sticky misalign_err flag. When the macro
//   is undefined, words are stored raw, the access-shape inputs are ignored
//   and misalign_err is held at 0.
//
// Handshake: a transfer happens on a rising edge when valid && ready on that
// side. Ready never depends on the same side's valid, so there are no
// combinational loops. The source must hold its inputs while valid && !ready.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous, active-high reset
//   in_valid      source presents a read-data word
//   in_ready      buffer can accept a word this cycle (count != DEPTH)
//   in_data       raw memory read data
//   in_addr_lo    low address bits of the access (byte lane select)
//   in_size       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   in_signed     1 = sign-extend, 0 = zero-extend
//   out_valid     head entry is valid (count != 0)
//   out_ready     sink accepts the head entry this cycle
//   out_data      head entry data, 0 when empty
//   count         number of occupied entries, 0..DEPTH
//   misalign_err  sticky flag, set by an accepted misaligned halfword
// -----------------------------------------------------------------------------
module mem_read_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_addr_lo,
    input  logic [1:0]               in_size,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Reject illegal geometries at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("mem_read_buffer: DEPTH must be a power of two >= 2");
    end

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_misalign;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_push_data;
    logic              w_misalign_push;

    // Both readies derive only from registered count.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push = in_valid  && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Load extraction (applied on the write side, so the sink sees the final
    // value and the read path stays a plain mux)
    // -------------------------------------------------------------------------
`ifdef MRB_LOAD_EXTRACT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = in_data[7:0];
        case (in_addr_lo)
            2'd0:    w_byte = in_data[7:0];
            2'd1:    w_byte = in_data[15:8];
            2'd2:    w_byte = in_data[23:16];
            default: w_byte = in_data[31:24];
        endcase
    end

    // Halfword lane is chosen by addr bit 1 only; bit 0 just flags misalignment.
    assign w_half = in_addr_lo[1] ? in_data[31:16] : in_data[15:0];

    always_comb begin
        w_push_data = in_data;
        case (in_size)
            SIZE_BYTE: w_push_data = {{24{in_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: w_push_data = {{16{in_signed & w_half[15]}}, w_half};
            default:   w_push_data = in_data;
        endcase
    end

    assign w_misalign_push = w_push && (in_size == SIZE_HALF) && in_addr_lo[0];
`else
    logic w_unused_ok;

    assign w_push_data     = in_data;
    assign w_misalign_push = 1'b0;
    // Access-shape inputs have no function without extraction.
    assign w_unused_ok     = ^{in_addr_lo, in_size, in_signed, SIZE_BYTE, SIZE_HALF};
`endif

    // -------------------------------------------------------------------------
    // Storage array: written on push only, no reset needed because entries are
    // only observable once count says they are occupied.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power
    // of two. Reset wins over any same-cycle push or pop.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_push) begin
            r_misalign <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count        = r_count;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_read_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_read_buffer
//
// Self-checking bench for mem_read_buffer (DATA_W = 32, DEPTH = 4). Expected
// head values are pushed to exp_q when the bench's own occupancy model says a
// word is accepted, and popped/compared when the sink takes the head. Works
// with or without MRB_LOAD_EXTRACT_EN; the expected stored value follows the
// same macro.
// -----------------------------------------------------------------------------
module tb_mem_read_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_addr_lo;
  logic [1:0]        in_size;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        count;
  logic              misalign_err;

  mem_read_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_addr_lo   (in_addr_lo),
    .in_size      (in_size),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .misalign_err (misalign_err)
  );

  // scoreboard / model state
  logic [DATA_W-1:0] exp_q[$];
  int                m_count;
  logic              m_mis;
  int                n_checks;
  int                n_fail;

  // Value the buffer should hold for a given access.
  function automatic logic [31:0] model_store(input logic [31:0] d, input logic [1:0] a,
                                              input logic [1:0] sz, input logic s);
    logic [31:0] sh;
`ifdef MRB_LOAD_EXTRACT_EN
    case (sz)
      2'b00: begin
        sh = d >> (8 * a);
        return (s && sh[7]) ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
      end
      2'b01: begin
        sh = d >> (16 * a[1]);
        return (s && sh[15]) ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
      end
      default: return d;
    endcase
`else
    sh = d;
    return sh;
`endif
  endfunction

  function automatic logic model_misalign(input logic [1:0] a, input logic [1:0] sz);
`ifdef MRB_LOAD_EXTRACT_EN
    return (sz == 2'b01) && a[0];
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle. Called at posedge+1; returns at the next posedge+1.
  // Checks in_ready against the model and, when a pop happens, the head data
  // against the scoreboard.
  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [1:0] a,
                             input logic [1:0] sz, input logic s, input logic rdy);
    logic do_push;
    logic do_pop;
    logic [31:0] exp_head;
    in_valid   = v;
    in_data    = d;
    in_addr_lo = a;
    in_size    = sz;
    in_signed  = s;
    out_ready  = rdy;
    #1;
    n_checks++;
    if (in_ready !== (m_count != DEPTH)) begin
      n_fail++;
      $display("FAIL in_ready: got %b exp %b (model count %0d)", in_ready, (m_count != DEPTH), m_count);
    end
    do_push = v && (m_count != DEPTH);
    do_pop  = rdy && (m_count != 0);
    if (do_pop) begin
      exp_head = exp_q.pop_front();
      n_checks++;
      if (out_data !== exp_head) begin
        n_fail++;
        $display("FAIL pop_data: got %h exp %h", out_data, exp_head);
      end
    end
    if (do_push) begin
      exp_q.push_back(model_store(d, a, sz, s));
      if (model_misalign(a, sz)) m_mis = 1'b1;
    end
    m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_data    = '0;
    in_addr_lo = '0;
    in_size    = 2'b10;
    in_signed  = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) drive_cycle(1'b0, 32'h0, 2'd0, 2'b10, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    exp_q.delete();
    m_count = 0;
    m_mis   = 1'b0;
    n_checks++;
    if (count !== 3'd0)        begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_checks++;
    if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_checks++;
    if (out_data !== 32'h0)    begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    n_checks++;
    if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    n_checks++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b exp 0", misalign_err); end
  endtask

  task automatic test_single_word();
    drive_cycle(1'b1, 32'h1122_3344, 2'd0, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1)        begin n_fail++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    n_checks++;
    if (out_data !== 32'h1122_3344) begin n_fail++; $display("FAIL single_data: got %h exp 11223344", out_data); end
    n_checks++;
    if (count !== 3'd1)            begin n_fail++; $display("FAIL single_count: got %0d exp 1", count); end
    drain();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 32'hA000_0000 + i, 2'd0, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd4)    begin n_fail++; $display("FAIL full_count: got %0d exp 4", count); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
    // 5th word held while full, then once with a pop in the same cycle (still refused)
    drive_cycle(1'b1, 32'hA000_0005, 2'd0, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd4)    begin n_fail++; $display("FAIL full_hold_count: got %0d exp 4", count); end
    drive_cycle(1'b1, 32'hA000_0005, 2'd0, 2'b10, 1'b0, 1'b1);
    n_checks++;
    if (count !== 3'd3)    begin n_fail++; $display("FAIL full_pushpop_count: got %0d exp 3", count); end
    drive_cycle(1'b1, 32'hA000_0005, 2'd0, 2'b10, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (count !== 3'd0)     begin n_fail++; $display("FAIL drain_count: got %0d exp 0", count); end
    n_checks++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL drain_out_data: got %h exp 0", out_data); end
    n_checks++;
    if (exp_q.size() != 0)  begin n_fail++; $display("FAIL drain_queue: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_extract();
    logic [31:0] exp_v [3];
`ifdef MRB_LOAD_EXTRACT_EN
    exp_v[0] = 32'hFFFF_FF80;
    exp_v[1] = 32'h0000_00FF;
    exp_v[2] = 32'hFFFF_80FF;
`else
    exp_v[0] = 32'h80FF_7F01;
    exp_v[1] = 32'h80FF_7F01;
    exp_v[2] = 32'h80FF_7F01;
`endif
    drive_cycle(1'b1, 32'h80FF_7F01, 2'd3, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (out_data !== exp_v[0]) begin n_fail++; $display("FAIL ext_byte_s: got %h exp %h", out_data, exp_v[0]); end
    drive_cycle(1'b1, 32'h80FF_7F01, 2'd2, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (out_data !== exp_v[1]) begin n_fail++; $display("FAIL ext_byte_u: got %h exp %h", out_data, exp_v[1]); end
    drive_cycle(1'b1, 32'h80FF_7F01, 2'd2, 2'b01, 1'b1, 1'b1);
    n_checks++;
    if (out_data !== exp_v[2]) begin n_fail++; $display("FAIL ext_half_s: got %h exp %h", out_data, exp_v[2]); end
    drive_cycle(1'b1, 32'hDEAD_BEEF, 2'd1, 2'b11, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'h1234_F678, 2'd0, 2'b01, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_misalign();
    drive_cycle(1'b1, 32'h0000_8001, 2'd1, 2'b01, 1'b1, 1'b0);
    n_checks++;
    if (misalign_err !== m_mis) begin n_fail++; $display("FAIL misalign_set: got %b exp %b", misalign_err, m_mis); end
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 32'h100 + i, 2'd0, 2'b10, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (misalign_err !== m_mis) begin n_fail++; $display("FAIL misalign_sticky: got %b exp %b", misalign_err, m_mis); end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 32'hB000_0000, 2'd0, 2'b10, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hB000_0001, 2'd0, 2'b10, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      drive_cycle(1'b1, 32'hB000_0000 + i, 2'd0, 2'b10, 1'b0, 1'b1);
      n_checks++;
      if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d exp 2 (step %0d)", count, i); end
    end
    drive_cycle(1'b1, 32'hB000_00FF, 2'd0, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_pre_rst_count: got %0d exp 3", count); end
    // reset with push and pop both requested
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    exp_q.delete();
    m_count = 0;
    m_mis   = 1'b0;
    n_checks++;
    if (count !== 3'd0)     begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", count); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0), $urandom(), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      n_checks++;
      if (count !== 3'(m_count)) begin n_fail++; $display("FAIL rand_count: got %0d exp %0d", count, m_count); end
      n_checks++;
      if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rand_misalign: got %b exp %b", misalign_err, m_mis); end
    end
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_count  = 0;
    m_mis    = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_full();
    test_extract();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
